// File: rtl/select_loader.sv
// select_loader: gathers per-output select codes into a shadow table over a
// valid/ready stream and, on a frame tick, swaps every written entry into the
// active table in a single cycle. Outputs therefore never switch source
// bitstreams part-way through a frame.
module select_loader #(
  parameter int BS            = 8,    // broadcast outputs (table entries), power of two
  parameter int NUM_BS        = 256,  // bitstreams in the group, power of two
  parameter int BS_SELECT     = $clog2(BS),
  parameter int NUM_BS_SELECT = $clog2(NUM_BS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [BS_SELECT-1:0]            wr_index,
  input  logic [NUM_BS_SELECT-1:0]        wr_code,
  input  logic                            wr_last,
  input  logic                            abort,
  input  logic                            frame_tick,
  output logic [NUM_BS_SELECT*BS-1:0]     bs_select,
  output logic                            pending,
  output logic                            commit_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // nothing written since the last commit/abort
    LOAD = 2'd1,  // at least one entry written, table still open
    PEND = 2'd2   // table closed, waiting for the frame boundary
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [NUM_BS_SELECT-1:0] shadow_reg [BS];
  logic [NUM_BS_SELECT-1:0] active_reg [BS];
  logic [BS-1:0]            dirty_reg;
  logic                     commit_done_reg;

  logic accept;
  logic commit;

  // Writes are refused while a closed table waits for its tick and while abort
  // is asserted, so abort always wins over an incoming write.
  assign wr_ready = (state_reg != PEND) && !abort;
  assign accept   = wr_valid && wr_ready;

  // A tick only commits a closed table; abort suppresses it. A tick that
  // arrives together with wr_last sees state LOAD/IDLE and so does not commit.
  assign commit   = (state_reg == PEND) && frame_tick && !abort;

  // Next-state logic for the load/commit sequencer.
  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, LOAD: begin
          if (accept) begin
            state_next = wr_last ? PEND : LOAD;
          end
        end
        PEND: begin
          if (frame_tick) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Dirty mask: set by accepted writes, cleared wholesale by commit or abort.
  // Accept cannot coincide with either (wr_ready is low in PEND and on abort).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty_reg <= '0;
    end else if (abort || commit) begin
      dirty_reg <= '0;
    end else if (accept) begin
      dirty_reg[wr_index] <= 1'b1;
    end
  end

  // Per-entry shadow and active registers.
  genvar gi;
  generate
    for (gi = 0; gi < BS; gi++) begin : g_entry
      // Shadow entry: captures the code of the latest accepted write to it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg[gi] <= '0;
        end else if (accept && (wr_index == BS_SELECT'(gi))) begin
          shadow_reg[gi] <= wr_code;
        end
      end

      // Active entry: identity after reset, replaced only by a commit of a dirty entry.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          active_reg[gi] <= NUM_BS_SELECT'(gi);
        end else if (commit && dirty_reg[gi]) begin
          active_reg[gi] <= shadow_reg[gi];
        end
      end

      assign bs_select[NUM_BS_SELECT*gi +: NUM_BS_SELECT] = active_reg[gi];
    end
  endgenerate

  // One-cycle acknowledge in the cycle after the commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_done_reg <= 1'b0;
    end else begin
      commit_done_reg <= commit;
    end
  end

  assign commit_done = commit_done_reg;
  assign pending     = (state_reg == PEND);

endmodule
